// File: rtl/mic_pkg.sv
// mic_pkg: shared parameters and types for the MIC memory arbiter slice.
// Ports: none (package). Provides sizes, op encoding and the queue entry layout.
// Imported by mic_if, mic_fifo and mic_arbiter.
package mic_pkg;

  localparam int NREQS  = 4;   // number of requesters
  localparam int PSIZE  = 20;  // words per requester page
  localparam int AWIDTH = 7;   // physical address width
  localparam int MWIDTH = 32;  // data width
  localparam int RDEPTH = 6;   // request queue depth

  localparam int RBITS  = (NREQS > 1) ? $clog2(NREQS) : 1;
  localparam int CWIDTH = $clog2(RDEPTH + 1);

  // Only these two encodings are ever written into the queue; an all-zero
  // entry (reset contents) therefore never looks like a write.
  typedef enum logic [1:0] {
    OP_RD = 2'b01,
    OP_WR = 2'b10
  } op_t;

  typedef struct packed {
    op_t               op;
    logic [AWIDTH-1:0] addr;
    logic [MWIDTH-1:0] data;
  } req_entry_t;

  localparam int RWIDTH = $bits(req_entry_t);

endpackage

// File: rtl/mic_if.sv
// mic_if: requester bus, memory port and status signals of the MIC arbiter.
// Ports: slave = arbiter side (takes req/we/offs/wdata/mem_ready/mem_rdata);
// master = environment side (requesters plus memory), directions mirrored.
interface mic_if;
  import mic_pkg::*;

  logic [NREQS-1:0]             req;
  logic [NREQS-1:0]             we;
  logic [NREQS-1:0][AWIDTH-1:0] offs;
  logic [NREQS-1:0][MWIDTH-1:0] wdata;
  logic [NREQS-1:0]             gnt;
  logic [NREQS-1:0]             err;

  logic                         mem_en;
  logic                         mem_ready;
  logic                         mem_we;
  logic [AWIDTH-1:0]            mem_addr;
  logic [MWIDTH-1:0]            mem_wdata;
  logic [MWIDTH-1:0]            mem_rdata;

  logic [NREQS-1:0]             rvalid;
  logic [MWIDTH-1:0]            rdata;
  logic [CWIDTH-1:0]            qcount;
  logic                         full;

  modport slave (
    input  req, we, offs, wdata, mem_ready, mem_rdata,
    output gnt, err, mem_en, mem_we, mem_addr, mem_wdata, rvalid, rdata, qcount, full
  );

  modport master (
    output req, we, offs, wdata, mem_ready, mem_rdata,
    input  gnt, err, mem_en, mem_we, mem_addr, mem_wdata, rvalid, rdata, qcount, full
  );

endinterface

// File: rtl/mic_fifo.sv
// mic_fifo: DEPTH-entry register queue, head presented combinationally.
// Ports: push/push_dat, pop, head_dat, count. Latency: pushed entry visible at head
// the cycle after push. Backpressure: push ignored when full unless popping the same cycle.
module mic_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             pop_ok;
  logic             push_ok;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    pop_ok  = pop && (count != '0);
    // A pop in the same cycle frees a slot, so a full queue still accepts.
    push_ok = push && ((count < CW'(DEPTH)) || pop_ok);
  end

  assign head_dat = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        store[wr_ptr] <= push_dat;
        wr_ptr        <= wrap_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= wrap_inc(rd_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mic_arbiter.sv
// mic_arbiter: round-robin arbiter sharing one MIC memory between NREQS paged requesters.
// Ports: clk, rst_n, bus (mic_if.slave). Latency: gnt/err combinational; entry at memory
// head next cycle; read data 1 cycle after transfer. Backpressure: mem_ready stalls the head;
// a full queue withholds gnt (valid offset) until a pop frees a slot.
module mic_arbiter
  import mic_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  mic_if.slave bus
);

  localparam int FW = RWIDTH + RBITS;

  // First requester at or after p, scanning circularly. MSB flags "found".
  // Scanning from the far end down lets the nearest requester overwrite.
  function automatic logic [RBITS:0] rr_pick(input logic [NREQS-1:0] r,
                                             input logic [RBITS-1:0] p);
    logic [RBITS:0] res;
    int             j;
    res = '0;
    for (int i = NREQS - 1; i >= 0; i--) begin
      j = int'(p) + i;
      if (j >= NREQS) j = j - NREQS;
      if (r[RBITS'(j)]) res = {1'b1, RBITS'(j)};
    end
    return res;
  endfunction

  function automatic logic [RBITS-1:0] rr_next(input logic [RBITS-1:0] idx);
    int j;
    j = int'(idx) + 1;
    if (j >= NREQS) j = 0;
    return RBITS'(j);
  endfunction

  logic [RBITS-1:0]  ptr;
  logic [RBITS:0]    pick;
  logic              win_vld;
  logic [RBITS-1:0]  win_idx;
  logic [AWIDTH-1:0] win_offs;
  logic              in_range;
  logic              mem_en;
  logic              pop;
  logic              slot_ok;
  logic              do_push;
  logic              do_err;
  req_entry_t        push_ent;
  logic [FW-1:0]     push_dat;
  logic [FW-1:0]     head_dat;
  req_entry_t        head_ent;
  logic [RBITS-1:0]  head_tag;
  logic [CWIDTH-1:0] count;
  logic              rd_pend;
  logic [RBITS-1:0]  rd_tag;

  always_comb begin
    pick     = rr_pick(bus.req, ptr);
    win_vld  = pick[RBITS];
    win_idx  = pick[RBITS-1:0];
    win_offs = bus.offs[win_idx];
    in_range = (win_offs < AWIDTH'(PSIZE));

    mem_en   = (count != '0);
    pop      = mem_en && bus.mem_ready;
    slot_ok  = (count < CWIDTH'(RDEPTH)) || pop;

    // Nothing is accepted or rejected while reset is asserted: the queue
    // would discard it anyway.
    do_push  = rst_n && win_vld && in_range && slot_ok;
    do_err   = rst_n && win_vld && !in_range;

    push_ent.op   = bus.we[win_idx] ? OP_WR : OP_RD;
    // Largest result is (NREQS-1)*PSIZE + PSIZE-1 = 79, fits AWIDTH.
    push_ent.addr = AWIDTH'(int'(win_idx) * PSIZE) + win_offs;
    push_ent.data = bus.wdata[win_idx];
    push_dat      = {win_idx, push_ent};

    {head_tag, head_ent} = head_dat;
  end

  mic_fifo #(
    .WIDTH (FW),
    .DEPTH (RDEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (do_push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr     <= '0;
      rd_pend <= 1'b0;
      rd_tag  <= '0;
    end else begin
      if (do_push || do_err) begin
        ptr <= rr_next(win_idx);
      end
      // Only reads come back; the tag remembers who asked.
      rd_pend <= pop && (head_ent.op == OP_RD);
      if (pop) begin
        rd_tag <= head_tag;
      end
    end
  end

  assign bus.gnt       = do_push ? (NREQS'(1) << win_idx) : '0;
  assign bus.err       = do_err  ? (NREQS'(1) << win_idx) : '0;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = (head_ent.op == OP_WR);
  assign bus.mem_addr  = head_ent.addr;
  assign bus.mem_wdata = head_ent.data;
  assign bus.rvalid    = rd_pend ? (NREQS'(1) << rd_tag) : '0;
  assign bus.rdata     = rd_pend ? bus.mem_rdata : '0;
  assign bus.qcount    = count;
  assign bus.full      = (count == CWIDTH'(RDEPTH));

endmodule

// File: tb/tb_mic_arbiter.sv
// tb_mic_arbiter: directed self-checking bench for mic_arbiter.
// Ports: none; drives a mic_if instance and models a 1-cycle-read memory.
// Inputs change 1 time unit after a rising edge; outputs are checked away from the edge.
module tb_mic_arbiter;
  import mic_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [MWIDTH-1:0] mem_model [2**AWIDTH];

  mic_if bus ();

  mic_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory: writes land at the transfer edge, read data appears the next cycle.
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_ready) begin
      if (bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem_model[bus.mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int fair_seq [8];
    fair_seq = '{3, 0, 1, 2, 3, 0, 1, 2};

    bus.req       = '0;
    bus.we        = '0;
    bus.offs      = '0;
    bus.wdata     = '0;
    bus.mem_ready = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_qcount", bus.qcount, 0);
    chk("rst_full",   bus.full,   0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata",  bus.rdata,  0);
    chk("rst_gnt",    bus.gnt,    0);
    chk("rst_err",    bus.err,    0);
    rst_n = 1'b1;

    // ---------------- single write, empty queue ----------------
    bus.mem_ready = 1'b1;
    bus.we        = 4'b1111;
    bus.req       = 4'b0001;
    bus.offs[0]   = 7'd3;
    bus.wdata[0]  = 32'hDEADBEEF;
    settle();
    chk("w0_gnt", bus.gnt, 4'b0001);
    chk("w0_err", bus.err, 4'b0000);
    tick();
    bus.req = '0;
    chk("w0_mem_en",    bus.mem_en,    1);
    chk("w0_mem_we",    bus.mem_we,    1);
    chk("w0_mem_addr",  bus.mem_addr,  3);
    chk("w0_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    bus.req      = 4'b0100;
    bus.offs[2]  = 7'd5;
    bus.wdata[2] = 32'h000000A5;
    settle();
    chk("w2_gnt", bus.gnt, 4'b0100);
    tick();
    bus.req = '0;
    chk("w2_qcount",   bus.qcount,   1);
    chk("w2_mem_addr", bus.mem_addr, 45);
    tick();
    chk("w2_drained", bus.qcount, 0);

    // ---------------- fairness (ptr is 3 here) ----------------
    for (int i = 0; i < NREQS; i++) begin
      bus.offs[i]  = 7'd1;
      bus.wdata[i] = 32'h50 + i;
    end
    bus.req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk($sformatf("fair_gnt%0d", k), bus.gnt, 4'b0001 << fair_seq[k]);
      tick();
    end
    bus.req = '0;
    tick();
    chk("fair_drained", bus.qcount, 0);

    // ---------------- full and back-pressure ----------------
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.req      = 4'b0010;
      bus.offs[1]  = 7'(k);
      bus.wdata[1] = 32'h100 + k;
      settle();
      chk($sformatf("full_gnt%0d", k), bus.gnt, 4'b0010);
      tick();
    end
    chk("full_qcount", bus.qcount, 6);
    chk("full_flag",   bus.full,   1);
    bus.offs[1]  = 7'd6;
    bus.wdata[1] = 32'h106;
    settle();
    chk("full_wait_gnt", bus.gnt, 4'b0000);
    // Out-of-range winner is rejected even with no queue space.
    bus.req     = 4'b1010;
    bus.offs[3] = 7'd20;
    settle();
    chk("full_err3", bus.err, 4'b1000);
    chk("full_err_gnt", bus.gnt, 4'b0000);
    tick();
    bus.req = 4'b0010;
    chk("full_hold_qcount", bus.qcount, 6);
    chk("full_head_addr",   bus.mem_addr, 20);
    chk("full_head_wdata",  bus.mem_wdata, 32'h100);
    bus.mem_ready = 1'b1;
    settle();
    chk("push_on_pop_gnt", bus.gnt, 4'b0010);
    tick();
    bus.req = '0;
    chk("push_on_pop_qcount", bus.qcount, 6);
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("drain_addr%0d", k),  bus.mem_addr,  20 + k);
      chk($sformatf("drain_wdata%0d", k), bus.mem_wdata, 32'h100 + k);
      tick();
    end
    chk("drain_qcount", bus.qcount, 0);
    chk("drain_mem_en", bus.mem_en, 0);

    // ---------------- range check ----------------
    bus.mem_ready = 1'b0;
    bus.req       = 4'b1000;
    bus.offs[3]   = 7'd20;
    settle();
    chk("range20_err", bus.err, 4'b1000);
    chk("range20_gnt", bus.gnt, 4'b0000);
    tick();
    chk("range20_qcount", bus.qcount, 0);
    bus.offs[3]  = 7'd19;
    bus.wdata[3] = 32'h79;
    settle();
    chk("range19_gnt", bus.gnt, 4'b1000);
    chk("range19_err", bus.err, 4'b0000);
    tick();
    bus.req = '0;
    chk("range19_qcount", bus.qcount, 1);
    chk("range19_addr",   bus.mem_addr, 79);
    bus.mem_ready = 1'b1;
    tick();
    chk("range19_drained", bus.qcount, 0);

    // ---------------- read after write ----------------
    bus.req      = 4'b0010;
    bus.we       = 4'b0010;
    bus.offs[1]  = 7'd0;
    bus.wdata[1] = 32'h1234;
    settle();
    chk("raw_wr_gnt", bus.gnt, 4'b0010);
    tick();
    bus.we = 4'b0000;
    settle();
    chk("raw_rd_gnt", bus.gnt, 4'b0010);
    tick();
    bus.req = '0;
    chk("raw_head_we",   bus.mem_we,   0);
    chk("raw_head_addr", bus.mem_addr, 20);
    chk("raw_no_rvalid", bus.rvalid,   0);
    tick();
    chk("raw_rvalid", bus.rvalid, 4'b0010);
    chk("raw_rdata",  bus.rdata,  32'h1234);
    tick();
    chk("raw_rvalid_off", bus.rvalid, 0);
    chk("raw_rdata_off",  bus.rdata,  0);

    // Read back the very first write through requester 0.
    bus.req     = 4'b0001;
    bus.offs[0] = 7'd3;
    settle();
    chk("rd0_gnt", bus.gnt, 4'b0001);
    tick();
    bus.req = '0;
    tick();
    chk("rd0_rvalid", bus.rvalid, 4'b0001);
    chk("rd0_rdata",  bus.rdata,  32'hDEADBEEF);
    tick();

    // ---------------- reset mid-operation ----------------
    bus.mem_ready = 1'b0;
    bus.we        = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      bus.req     = 4'b0100;
      bus.offs[2] = 7'(k);
      settle();
      chk($sformatf("mid_gnt%0d", k), bus.gnt, 4'b0100);
      tick();
    end
    bus.req = '0;
    chk("mid_qcount", bus.qcount, 4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_qcount", bus.qcount, 0);
    chk("mid_rst_mem_en", bus.mem_en, 0);
    chk("mid_rst_full",   bus.full,   0);
    chk("mid_rst_rvalid", bus.rvalid, 0);
    bus.req     = 4'b1100;
    bus.offs[2] = 7'd1;
    bus.offs[3] = 7'd1;
    settle();
    chk("mid_ptr_gnt", bus.gnt, 4'b0100);
    tick();
    bus.req = '0;
    chk("mid_after_qcount", bus.qcount, 1);
    chk("mid_after_addr",   bus.mem_addr, 41);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
